// File: rtl/logic_unit_pkg.sv
// Shared operation encodings for the pipelined logic unit.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND      = 3'd0,
    OP_OR       = 3'd1,
    OP_XOR      = 3'd2,
    OP_NAND     = 3'd3,
    OP_NOR      = 3'd4,
    OP_XNOR     = 3'd5,
    OP_ACC_XOR  = 3'd6,
    OP_ACC_LOAD = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_comb.sv
// Purely combinational bitwise operation decode; the accumulator value is
// supplied by the caller, which owns all state.
module logic_op_comb
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] acc,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:      result = A & B;
      OP_OR:       result = A | B;
      OP_XOR:      result = A ^ B;
      OP_NAND:     result = ~(A & B);
      OP_NOR:      result = ~(A | B);
      OP_XNOR:     result = ~(A ^ B);
      OP_ACC_XOR:  result = acc ^ A;
      OP_ACC_LOAD: result = A;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// One-stage valid/ready logic unit with a single output register and an
// internal accumulator; full throughput when downstream is always ready.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Z
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result;
  logic             accept;
  logic             consume;
  logic             acc_op;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign acc_op   = (op == OP_ACC_XOR) || (op == OP_ACC_LOAD);

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .A      (A),
    .B      (B),
    .acc    (acc),
    .op     (op),
    .result (result)
  );

  // For both accumulator ops the result equals the new accumulator value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      F         <= '0;
      Z         <= 1'b1;
      acc       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      F         <= result;
      Z         <= (result == '0);
      if (acc_op) acc <= result;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe at WIDTH=8, with WIDTH=1 and WIDTH=32
// instances sharing the stimulus for the width-generality scenario.
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a_bus;
  logic [63:0] b_bus;
  logic [2:0]  op;

  logic        in_ready8, out_valid8, z8;
  logic [7:0]  f8;
  logic        in_ready1, out_valid1, z1;
  logic [0:0]  f1;
  logic        in_ready32, out_valid32, z32;
  logic [31:0] f32;

  int checks;
  int failures;

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .A(a_bus[7:0]), .B(b_bus[7:0]), .op(op), .out_valid(out_valid8),
    .out_ready(out_ready), .F(f8), .Z(z8)
  );

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .A(a_bus[0:0]), .B(b_bus[0:0]), .op(op), .out_valid(out_valid1),
    .out_ready(out_ready), .F(f1), .Z(z1)
  );

  logic_unit_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .A(a_bus[31:0]), .B(b_bus[31:0]), .op(op), .out_valid(out_valid32),
    .out_ready(out_ready), .F(f32), .Z(z32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_bus = '0; b_bus = '0; op = 3'd0;
    tick(); tick();
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid8); end
    checks++; if (f8 !== 8'h00) begin failures++; $display("[TB] FAIL reset_F got=%h want=00", f8); end
    checks++; if (z8 !== 1'b1) begin failures++; $display("[TB] FAIL reset_Z got=%b want=1", z8); end
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready8); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready got=%b want=1", in_ready8); end
    // load a pending result, then reset between edges
    in_valid = 1'b1; op = 3'd7; a_bus = 64'h55;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid8 !== 1'b1 || f8 !== 8'h55) begin failures++; $display("[TB] FAIL pending_load got=%b/%h want=1/55", out_valid8, f8); end
    checks++; if (in_ready8 !== 1'b0) begin failures++; $display("[TB] FAIL pending_in_ready got=%b want=0", in_ready8); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("[TB] FAIL async_out_valid got=%b want=0", out_valid8); end
    checks++; if (f8 !== 8'h00) begin failures++; $display("[TB] FAIL async_F got=%h want=00", f8); end
    checks++; if (z8 !== 1'b1) begin failures++; $display("[TB] FAIL async_Z got=%b want=1", z8); end
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("[TB] FAIL async_in_ready got=%b want=1", in_ready8); end
    tick();
    rst_n = 1'b1;
    // accumulator must start from zero again
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd6; a_bus = 64'h0F;
    tick();
    in_valid = 1'b0;
    checks++; if (f8 !== 8'h0F) begin failures++; $display("[TB] FAIL acc_cleared got=%h want=0f", f8); end
    tick();
  endtask

  task automatic test_two_operand();
    logic [7:0] expv [6];
    expv = '{8'h4A, 8'hDF, 8'h95, 8'hB5, 8'h20, 8'h6A};
    out_ready = 1'b1; in_valid = 1'b1; a_bus = 64'hCA; b_bus = 64'h5F;
    for (int i = 0; i < 6; i++) begin
      op = 3'(i);
      tick();
      checks++; if (out_valid8 !== 1'b1 || f8 !== expv[i] || z8 !== 1'b0) begin
        failures++; $display("[TB] FAIL op%0d got v=%b F=%h Z=%b want v=1 F=%h Z=0", i, out_valid8, f8, z8, expv[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("[TB] FAIL drain_out_valid got=%b want=0", out_valid8); end
  endtask

  task automatic test_zero_flag();
    out_ready = 1'b1; in_valid = 1'b1; a_bus = 64'hF0; b_bus = 64'h0F; op = 3'd0;
    tick();
    checks++; if (f8 !== 8'h00 || z8 !== 1'b1) begin failures++; $display("[TB] FAIL zflag_and got F=%h Z=%b want F=00 Z=1", f8, z8); end
    op = 3'd1;
    tick();
    checks++; if (f8 !== 8'hFF || z8 !== 1'b0) begin failures++; $display("[TB] FAIL zflag_or got F=%h Z=%b want F=ff Z=0", f8, z8); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_accumulator();
    logic [2:0] ops  [5];
    logic [7:0] as   [5];
    logic [7:0] expf [5];
    ops  = '{3'd7, 3'd0, 3'd6, 3'd0, 3'd6};
    as   = '{8'h3C, 8'h00, 8'hFF, 8'hFF, 8'hC3};
    expf = '{8'h3C, 8'h00, 8'hC3, 8'h00, 8'h00};
    out_ready = 1'b1; in_valid = 1'b1; b_bus = 64'h00;
    for (int i = 0; i < 5; i++) begin
      op = ops[i]; a_bus = {56'h0, as[i]};
      tick();
      checks++; if (f8 !== expf[i] || z8 !== (expf[i] == 8'h00)) begin
        failures++; $display("[TB] FAIL acc_step%0d got F=%h Z=%b want F=%h", i, f8, z8, expf[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd1; a_bus = 64'h12; b_bus = 64'h34;
    tick();
    checks++; if (out_valid8 !== 1'b1 || f8 !== 8'h36) begin failures++; $display("[TB] FAIL bp_first got v=%b F=%h want v=1 F=36", out_valid8, f8); end
    checks++; if (in_ready8 !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready got=%b want=0", in_ready8); end
    op = 3'd7; a_bus = 64'hAA; b_bus = 64'h55;
    tick(); tick();
    checks++; if (out_valid8 !== 1'b1 || f8 !== 8'h36 || z8 !== 1'b0) begin
      failures++; $display("[TB] FAIL bp_hold got v=%b F=%h Z=%b want v=1 F=36 Z=0", out_valid8, f8, z8);
    end
    op = 3'd2;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready got=%b want=1", in_ready8); end
    tick();
    checks++; if (out_valid8 !== 1'b1 || f8 !== 8'hFF) begin failures++; $display("[TB] FAIL bp_same_edge got v=%b F=%h want v=1 F=ff", out_valid8, f8); end
    // accumulator was 00; the blocked op7 must not have loaded AA
    op = 3'd6; a_bus = 64'h00;
    tick();
    checks++; if (f8 !== 8'h00 || z8 !== 1'b1) begin failures++; $display("[TB] FAIL bp_acc_untouched got F=%h Z=%b want F=00 Z=1", f8, z8); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain got=%b want=0", out_valid8); end
  endtask

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] a,
                                         input logic [63:0] b, input logic [63:0] acc);
    case (o)
      3'd0: ref_op = a & b;
      3'd1: ref_op = a | b;
      3'd2: ref_op = a ^ b;
      3'd3: ref_op = ~(a & b);
      3'd4: ref_op = ~(a | b);
      3'd5: ref_op = ~(a ^ b);
      3'd6: ref_op = acc ^ a;
      default: ref_op = a;
    endcase
  endfunction

  task automatic test_widths();
    logic [2:0]  wop [11];
    logic [63:0] wa  [11];
    logic [63:0] wb  [11];
    logic [63:0] acc1, acc32, r1, r32;
    wop = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6, 3'd6, 3'd0, 3'd6};
    wa  = '{64'h1234ABCA, 64'h1234ABCA, 64'h1234ABCA, 64'h1234ABCA, 64'h1234ABCA, 64'h1234ABCA,
            64'h3C3C003C, 64'hFFFFFFFF, 64'hC3C3FFC3, 64'hFFFFFFFF, 64'h00000001};
    wb  = '{64'h0F0FF05F, 64'h0F0FF05F, 64'h0F0FF05F, 64'h0F0FF05F, 64'h0F0FF05F, 64'h0F0FF05F,
            64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 64'hFFFFFFFF};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    acc1 = '0; acc32 = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      op = wop[i]; a_bus = wa[i]; b_bus = wb[i];
      r1  = ref_op(wop[i], wa[i], wb[i], acc1)  & 64'h1;
      r32 = ref_op(wop[i], wa[i], wb[i], acc32) & 64'hFFFF_FFFF;
      if (wop[i] >= 3'd6) begin acc1 = r1; acc32 = r32; end
      tick();
      checks++; if (out_valid1 !== 1'b1 || in_ready1 !== 1'b1 || {63'h0, f1} !== r1 || z1 !== (r1 == 64'h0)) begin
        failures++; $display("[TB] FAIL w1_step%0d got v=%b F=%h Z=%b want v=1 F=%h", i, out_valid1, f1, z1, r1);
      end
      checks++; if (out_valid32 !== 1'b1 || in_ready32 !== 1'b1 || {32'h0, f32} !== r32 || z32 !== (r32 == 64'h0)) begin
        failures++; $display("[TB] FAIL w32_step%0d got v=%b F=%h Z=%b want v=1 F=%h", i, out_valid32, f32, z32, r32);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_two_operand();
    test_zero_flag();
    test_accumulator();
    test_backpressure();
    test_widths();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal 1..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand set on A, B, op is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port A  input  WIDTH  first operand.
REQ-007 SHALL have port B  input  WIDTH  second operand.
REQ-008 SHALL have port op  input  3  operation select, encoding per REQ-013.
REQ-009 SHALL have port out_valid  output  1  F and Z hold a result.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-011 SHALL have port F  output  WIDTH  registered result.
REQ-012 SHALL have port Z  output  1  registered flag, 1 when F is all-zero.

Function
REQ-013 SHALL decode op as: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ACC_XOR (acc ^ A), 7 ACC_LOAD (A).
REQ-014 SHALL define accept as in_valid && in_ready, and consume as out_valid && out_ready.
REQ-015 SHALL drive in_ready = !out_valid || out_ready (combinational; one-entry output register, full throughput).
REQ-016 SHALL, on accept, register the op result into F and (result == 0) into Z on the same edge; latency one cycle from accept to out_valid.
REQ-017 SHALL set out_valid on accept, clear it on consume without accept, and keep it at 1 on simultaneous consume and accept (back-to-back).
REQ-018 SHALL hold F, Z, and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL keep an internal WIDTH-bit accumulator acc, updated only on accept with op 6 (acc <= acc ^ A) or op 7 (acc <= A); ops 0-5 leave acc unchanged.
REQ-020 SHALL ignore B for ops 6 and 7.
REQ-021 SHALL use the pre-update acc value when computing an op-6 result; the result equals the new acc.
REQ-022 SHALL ignore A, B, and op when in_valid=0 or in_ready=0; there is no state change without accept.
REQ-023 SHALL produce bitwise results only, with no carries and no width growth; all results are exactly WIDTH bits.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force out_valid=0, F=0, Z=1, and acc=0.
REQ-025 SHALL drive in_ready=1 during and immediately after reset.
REQ-026 SHALL discard any pending result and accumulator contents on reset mid-operation; the first accept after release behaves as from power-up.

Structure
REQ-027 SHALL take op encodings (localparam/enum OP_AND..OP_ACC_LOAD) from shared package logic_unit_pkg.
REQ-028 SHALL place the combinational op decode in sub-module logic_op_comb (inputs A, B, acc, op; output result), instantiated once.
REQ-029 SHALL contain all registers (F, Z, out_valid, acc) in logic_unit_pipe only.

Verification
REQ-030 SHALL cover the reset check: WIDTH=8; assert rst_n=0 mid-run with out_valid=1 -> out_valid=0, F=8'h00, Z=1, in_ready=1 immediately without a clock edge.
REQ-031 SHALL cover the two-operand ops: A=8'hCA, B=8'h5F, ops 0..5 streamed back-to-back with out_ready=1 -> F = 4A,DF,95,B5,20,6A on consecutive cycles with out_valid continuously 1.
REQ-032 SHALL cover the Z flag: A=8'hF0, B=8'h0F, op=0 -> F=8'h00, Z=1; then op=1 -> F=8'hFF, Z=0.
REQ-033 SHALL cover accumulator operation: op7 A=8'h3C, then op6 A=8'hFF, then op6 A=8'hC3 -> F = 3C, C3, 00 with Z=1 on the third; an interleaved op0 leaves acc unchanged.
REQ-034 SHALL cover backpressure: hold out_ready=0 with a result pending -> in_ready=0, F stable, a new in_valid ignored; raise out_ready with in_valid=1 -> consume and accept on the same edge, new F next cycle.
REQ-035 SHALL cover width generality: rerun REQ-031 and REQ-033 with WIDTH=1 and WIDTH=32 against a reference model, with zero mismatches.
